// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC, imem req/ack fetch, instruction register, next-PC select
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic             branch,
  input  logic             zero,
  input  logic             jmp,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [31:0]        br_offset;
  logic [31:0]        next_pc;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // jmp outranks a taken branch; all sums wrap modulo 2^32
  always_comb begin
    next_pc = pc_plus4;
    if (jmp) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + br_offset;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          pc_d      = next_pc;
          retired_d = retired_q + 1'b1;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= {RESET_PC[31:2], 2'b00};
      instr_q   <= 32'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign pc          = pc_q;
  assign retired     = retired_q;

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the main decode controller. Holds the PC and issues fetches to instruction memory over a req/ack handshake. Latches the returned word into an instruction register and presents op (instr[31:26]) to the controller. Consumes the controller's Branch/JMP outputs plus the ALU zero flag to select the next PC when the execute side signals completion.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address (= pc while imem_req high)
imem_ack  input  1  memory has valid imem_rdata this cycle
imem_rdata  input  32  instruction word from memory
instr  output  32  instruction register
op  output  6  instr[31:26], drives controller OP
instr_valid  output  1  instr held for execute (high throughout EXEC)
exec_done  input  1  execute/writeback complete; advance PC
branch  input  1  controller Branch
zero  input  1  ALU zero flag
jmp  input  1  controller JMP
pc  output  32  current PC
pc_plus4  output  32  pc + 4, combinational
retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset (rst high at clk edge, any state): pc=RESET_PC, instr=0, state=IDLE, retired=0. Outputs after reset: imem_req=0, instr_valid=0, op=0. Reset overrides every other input in the same cycle.
- FSM states IDLE, FETCH, EXEC:
  - IDLE: outputs quiet; unconditionally -> FETCH next cycle. First imem_req appears 1 cycle after rst drops.
  - FETCH: imem_req=1, imem_addr=pc, both held stable until ack. On imem_ack: instr<=imem_rdata, -> EXEC. Ack in the first FETCH cycle is legal (zero-wait memory).
  - EXEC: imem_req=0, instr_valid=1. On exec_done: pc<=next_pc, retired<=retired+1, -> FETCH. Otherwise hold.
- Signals outside their state are ignored: imem_ack outside FETCH, exec_done outside EXEC.
- Minimum instruction period: 2 cycles (FETCH with immediate ack, EXEC with immediate exec_done).
- next_pc, evaluated in the exec_done cycle, in priority order:
  1. jmp=1: {pc_plus4[31:28], instr[25:0], 2'b00}
  2. branch=1 & zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})
  3. otherwise: pc_plus4
- jmp has priority over branch when both are asserted.
- All PC arithmetic is 32-bit modulo 2^32. 0xFFFF_FFFC + 4 = 0x0000_0000; branch offsets wrap likewise.
- pc[1:0] is always 0.
- retired wraps from all-ones to 0.
- pc, instr, and op are stable throughout EXEC; the controller sees a constant OP for the whole instruction.
- Reset asserted during FETCH with a pending ack: the ack is discarded, instr=0, imem_req low in the cycle after the reset edge.

Test Plan:
- Reset release: rst high 2 cycles then low; RESET_PC=0 -> imem_req=1, imem_addr=0 one cycle later; instr=0, retired=0.
- Sequential: ack with rdata 0x8C01_0004 (lw), exec_done with branch=jmp=0 -> op=6'h23 during EXEC; next fetch addr 0x4; retired=1.
- Wait states: ack delayed 3 cycles -> imem_req and imem_addr unchanged for all 4 FETCH cycles; ack during EXEC ignored, instr unchanged.
- Branch: pc=0x8, instr 0x1000_0003, branch=1, zero=1 -> next pc 0x18. Same with zero=0 -> 0xC. pc=0x20, instr 0x1000_FFFF taken -> 0x20.
- Jump: pc=0x4, instr 0x0800_0010, jmp=1 and branch=1, zero=1 -> next pc 0x40 (jmp wins). pc=0xFFFF_FFFC, no branch/jump -> next pc 0x0.
- Reset mid-operation: rst in FETCH cycle with imem_ack=1, rdata=0x1234_5678 -> instr=0, pc=RESET_PC, state IDLE, retired=0.
